// File: rtl/store_buffer.sv
// Posted-write buffer: in-order FIFO of stores with load forwarding. A store drains at the earliest one cycle after it is accepted.
// Backpressure: st_ready falls when the buffer is full. A load that is served without a stall owns the memory port.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  output logic                     mem_write,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [AW-1:0] ent_addr_d [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];
  logic [DW-1:0] ent_data_d [DEPTH];

  logic          enq;
  logic          drain;
  logic          fwd_hit;
  logic          fwd_overlap;
  logic [DW-1:0] fwd_data;
  logic [AW-1:0] ld_addr_p1;
  logic [AW-1:0] ld_addr_m1;
  logic [PW-1:0] idx;

  assign st_ready = (count_q != FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign enq      = st_valid && st_ready;

  // Walk oldest to youngest so the last exact match wins.
  always_comb begin
    fwd_hit     = 1'b0;
    fwd_overlap = 1'b0;
    fwd_data    = '0;
    idx         = '0;
    ld_addr_p1  = ld_addr + AW'(1);
    ld_addr_m1  = ld_addr - AW'(1);
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (ent_addr_q[idx] == ld_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = ent_data_q[idx];
        end
        if (ent_addr_q[idx] == ld_addr_p1 || ent_addr_q[idx] == ld_addr_m1) begin
          fwd_overlap = 1'b1;
        end
      end
    end
  end

  assign ld_stall = ld_valid && fwd_overlap;
  assign ld_hit   = ld_valid && fwd_hit && !fwd_overlap;
  assign ld_data  = ld_hit ? fwd_data : '0;

  // Reset suppresses the write strobe so no stale entry escapes in the reset cycle.
  assign drain     = !rst && !empty && (!ld_valid || ld_stall);
  assign mem_write = drain;
  assign mem_addr  = drain ? ent_addr_q[rd_ptr_q] : '0;
  assign mem_wdata = drain ? ent_data_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (enq) begin
      ent_addr_d[wr_ptr_q] = st_addr;
      ent_data_d[wr_ptr_q] = st_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule
